// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Loads a length-prefixed, XOR-checksummed byte stream into a
//            48-bit program store while holding the CPU in reset.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int WE_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [47:0]           prog_data,
  output logic                  prog_we,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  localparam int              WE_W      = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [WE_W-1:0] WE_LAST   = WE_W'(WE_CYCLES - 1);
  localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LEN_LO = 4'd1,
    LEN_HI = 4'd2,
    BYTES  = 4'd3,
    SETUP  = 4'd4,
    WRITE  = 4'd5,
    HOLD   = 4'd6,
    CHECK  = 4'd7,
    DONE   = 4'd8,
    ERROR  = 4'd9
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [15:0]     len_q;
  logic [2:0]      idx;
  logic [7:0]      chk;
  logic [WE_W-1:0] we_cnt;
  logic            xfer;
  logic            start_ok;
  logic [16:0]     n_full;

  assign rx_ready = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == BYTES)  || (state == CHECK);
  assign prog_we  = (state == WRITE);
  assign xfer     = rx_valid && rx_ready;
  assign n_full   = {1'b0, rx_data, len_q[7:0]};
  assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = LEN_LO;
      LEN_LO: if (xfer) state_nxt = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (n_full > MAX_WORDS)     state_nxt = ERROR;
          else if (n_full == 17'd0)   state_nxt = CHECK;
          else                        state_nxt = BYTES;
        end
      end
      BYTES:  if (xfer && idx == 3'd5) state_nxt = SETUP;
      SETUP:  state_nxt = WRITE;
      WRITE:  if (we_cnt == WE_LAST) state_nxt = HOLD;
      HOLD:   state_nxt = ((word_count + 16'd1) == len_q) ? CHECK : BYTES;
      CHECK:  if (xfer) state_nxt = (rx_data == chk) ? DONE : ERROR;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything, including a same-cycle start.
    if (busy && abort) state_nxt = ERROR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= 16'd0;
      idx        <= 3'd0;
      chk        <= 8'd0;
      we_cnt     <= '0;
      prog_addr  <= '0;
      prog_data  <= 48'd0;
      word_count <= 16'd0;
      busy       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (start_ok) begin
        done       <= 1'b0;
        error      <= 1'b0;
        word_count <= 16'd0;
        prog_addr  <= '0;
        chk        <= 8'd0;
        busy       <= 1'b1;
        cpu_hold   <= 1'b1;
      end
      case (state)
        LEN_LO: if (xfer) len_q[7:0] <= rx_data;
        LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= rx_data;
            idx         <= 3'd0;
          end
        end
        BYTES: begin
          if (xfer) begin
            prog_data[{idx, 3'b000} +: 8] <= rx_data;
            chk <= chk ^ rx_data;
            idx <= idx + 3'd1;
          end
        end
        SETUP: we_cnt <= '0;
        WRITE: we_cnt <= we_cnt + 1'b1;
        HOLD: begin
          prog_addr  <= prog_addr + ADDR_WIDTH'(1);
          word_count <= word_count + 16'd1;
          idx        <= 3'd0;
        end
        default: ;
      endcase
      if (state_nxt == DONE && state != DONE) begin
        done     <= 1'b1;
        busy     <= 1'b0;
        cpu_hold <= 1'b0;
      end
      if (state_nxt == ERROR && state != ERROR) begin
        error    <= 1'b1;
        busy     <= 1'b0;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Table-driven checks of prog_loader plus reset/abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int AW   = 4;
  localparam int WE   = 2;
  localparam int MAXW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-1:0] prog_addr;
  logic [47:0]   prog_data;
  logic          prog_we;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   word_count;

  int n_checks = 0;
  int n_fail   = 0;

  prog_loader #(.ADDR_WIDTH(AW), .WE_CYCLES(WE)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Thirteen-word image: 12 register/port instructions then a jump to 0.
  logic [47:0] ref13 [13] = '{
    48'h10_00_00_00_01_01, 48'h10_00_00_00_02_02, 48'h10_00_00_00_7F_03,
    48'h20_00_00_01_02_01, 48'h21_00_00_03_01_02, 48'h30_00_00_00_40_01,
    48'h31_00_00_00_41_02, 48'h40_00_00_00_03_AA, 48'h41_00_00_00_55_03,
    48'h50_00_00_00_01_04, 48'h51_00_00_00_04_05, 48'h60_00_00_00_05_06,
    48'hF0_00_00_00_00_00
  };

  typedef struct {
    logic [15:0] n;
    int          kind;
    bit          bad_chk;
    bit          gappy;
    bit          exp_done;
    bit          exp_err;
    int          exp_wc;
    int          exp_addr;
    int          exp_writes;
  } vec_t;

  vec_t vecs [7];

  logic [AW-1:0] wr_addr_q [$];
  logic [47:0]   wr_data_q [$];
  bit            we_prev = 1'b0;
  int            we_len  = 0;
  logic [AW-1:0] last_addr = '0;
  logic [47:0]   last_data = 48'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] word_of(input int kind, input int i);
    case (kind)
      0:       return 48'h665544332211;
      1:       return ref13[i];
      default: return {8'hE0, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'(i)};
    endcase
  endfunction

  // Write-cycle monitor: captures each pulse, checks width, setup/hold and stall.
  always @(negedge clk) begin
    if (prog_we) begin
      if (!we_prev) begin
        wr_addr_q.push_back(prog_addr);
        wr_data_q.push_back(prog_data);
        we_len = 0;
        check("setup_addr", 64'(last_addr), 64'(prog_addr));
        check("setup_data", 64'(last_data), 64'(prog_data));
      end else begin
        check("we_addr_stable", 64'(prog_addr), 64'(wr_addr_q[$]));
        check("we_data_stable", 64'(prog_data), 64'(wr_data_q[$]));
      end
      we_len++;
      check("rx_ready_in_write", 64'(rx_ready), 64'(0));
    end else if (we_prev) begin
      check("we_width", 64'(we_len), 64'(WE));
      check("hold_addr", 64'(prog_addr), 64'(wr_addr_q[$]));
      check("hold_data", 64'(prog_data), 64'(wr_data_q[$]));
    end
    we_prev   = prog_we;
    last_addr = prog_addr;
    last_data = prog_data;
  end

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int t = 0;
    if (gappy) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_timeout: rx_ready 0, required 1");
    end
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0]  c = 8'd0;
    logic [47:0] w;
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    check($sformatf("v%0d_busy_start", id), 64'(busy), 64'(1));
    check($sformatf("v%0d_hold_start", id), 64'(cpu_hold), 64'(1));
    check($sformatf("v%0d_done_clr", id), 64'(done), 64'(0));
    send_byte(v.n[7:0], v.gappy);
    send_byte(v.n[15:8], v.gappy);
    if (int'(v.n) <= MAXW) begin
      for (int i = 0; i < int'(v.n); i++) begin
        w = word_of(v.kind, i);
        for (int k = 0; k < 6; k++) begin
          c = c ^ w[8*k +: 8];
          send_byte(w[8*k +: 8], v.gappy);
        end
      end
      send_byte(v.bad_chk ? 8'h00 : c, v.gappy);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    for (int t = 0; t < 10 && busy; t++) @(negedge clk);
    check($sformatf("v%0d_busy", id), 64'(busy), 64'(0));
    check($sformatf("v%0d_cpu_hold", id), 64'(cpu_hold), 64'(0));
    check($sformatf("v%0d_done", id), 64'(done), 64'(v.exp_done));
    check($sformatf("v%0d_error", id), 64'(error), 64'(v.exp_err));
    check($sformatf("v%0d_word_count", id), 64'(word_count), 64'(v.exp_wc));
    check($sformatf("v%0d_prog_addr", id), 64'(prog_addr), 64'(v.exp_addr));
    check($sformatf("v%0d_n_writes", id), 64'(wr_addr_q.size()), 64'(v.exp_writes));
    for (int i = 0; i < wr_addr_q.size() && i < v.exp_writes; i++) begin
      check($sformatf("v%0d_wr%0d_addr", id, i), 64'(wr_addr_q[i]), 64'(i % MAXW));
      check($sformatf("v%0d_wr%0d_data", id, i), 64'(wr_data_q[i]), 64'(word_of(v.kind, i)));
    end
  endtask

  initial begin
    //          n       kind bad gap done err wc  addr writes
    vecs[0] = '{16'd1,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1,  1,  1};
    vecs[1] = '{16'd13, 1, 1'b0, 1'b0, 1'b1, 1'b0, 13, 13, 13};
    vecs[2] = '{16'd1,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1,  1,  1};
    vecs[3] = '{16'd0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 0,  0,  0};
    vecs[4] = '{16'd13, 1, 1'b0, 1'b1, 1'b1, 1'b0, 13, 13, 13};
    vecs[5] = '{16'd16, 2, 1'b0, 1'b0, 1'b1, 1'b0, 16, 0,  16};
    vecs[6] = '{16'd17, 2, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0,  0};

    repeat (3) @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'(0));
    check("rst_prog_addr", 64'(prog_addr), 64'(0));
    check("rst_prog_data", 64'(prog_data), 64'(0));
    check("rst_prog_we", 64'(prog_we), 64'(0));
    check("rst_cpu_hold", 64'(cpu_hold), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset in the middle of a payload, between clock edges.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_cpu_hold", 64'(cpu_hold), 64'(0));
    check("mid_rst_rx_ready", 64'(rx_ready), 64'(0));
    check("mid_rst_prog_data", 64'(prog_data), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_error", 64'(error), 64'(0));
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0], 10);

    // Abort mid-payload, coinciding with a start that must be ignored.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_error", 64'(error), 64'(1));
    check("abort_done", 64'(done), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_cpu_hold", 64'(cpu_hold), 64'(0));
    check("abort_rx_ready", 64'(rx_ready), 64'(0));
    check("abort_word_count", 64'(word_count), 64'(0));
    // abort while idle in ERROR changes nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_error", 64'(error), 64'(1));
    check("idle_abort_busy", 64'(busy), 64'(0));
    run_vec(vecs[0], 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Sequences loading of the 48-bit-wide program store (six 8-bit byte-lane ROM/RAM chips) from an 8-bit byte stream, e.g. a UART or host link.
- Accepts a length-prefixed, checksummed image, assembles six little-endian bytes per instruction word and generates timed write cycles.
- Holds the CPU in reset (cpu_hold) for the duration of the load, so program memory is owned by the loader or the CPU, never both.

Parameters:
- ADDR_WIDTH, 16, program address width; capacity is 2**ADDR_WIDTH words.
- WE_CYCLES, 2, width of the prog_we pulse in clocks (>=1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; only honoured in IDLE, DONE or ERROR.
- abort  in  1  cancel an in-progress load.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts rx_data this cycle; a byte transfers when rx_valid && rx_ready.
- prog_addr  out  ADDR_WIDTH  program memory write address.
- prog_data  out  48  instruction word; byte k = stream byte k of the word, so data[7:0] is first.
- prog_we  out  1  program memory write strobe.
- cpu_hold  out  1  holds the CPU in reset while high.
- busy  out  1  a load is in progress.
- done  out  1  last load completed with a good checksum.
- error  out  1  last load failed (bad checksum, oversize or abort).
- word_count  out  16  words written so far in the current or last load.

Behaviour:
- Reset values: rx_ready=0, prog_addr=0, prog_data=0, prog_we=0, cpu_hold=0, busy=0, done=0, error=0, word_count=0, state=IDLE. A reset mid-load abandons the load immediately; memory contents already written are not undone.
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 6*N payload bytes, then CHK. CHK is the XOR of all payload bytes; length bytes are excluded from the checksum.
- States:
  - IDLE / DONE / ERROR: rx_ready=0. On start, clear done, error, word_count, prog_addr and the checksum accumulator; set busy=1 and cpu_hold=1; go to LEN_LO.
  - LEN_LO: rx_ready=1; on transfer, latch N[7:0] and go to LEN_HI.
  - LEN_HI: rx_ready=1; on transfer, latch N[15:8]. If N > 2**ADDR_WIDTH, go to ERROR; if N==0, go to CHECK; otherwise go to BYTES with byte index = 0.
  - BYTES: rx_ready=1; each transfer writes the byte to lane[index] and XORs it into the checksum. On the transfer with index==5, go to WRITE; otherwise increment index.
  - WRITE: rx_ready=0; prog_we=1 for exactly WE_CYCLES clocks. prog_addr and prog_data are stable from one cycle before prog_we rises until one cycle after it falls (setup and hold), which adds a 1-cycle SETUP state before WRITE and a 1-cycle HOLD state after it.
  - HOLD: increment prog_addr and word_count. If word_count now equals N, go to CHECK; otherwise go to BYTES with index = 0.
  - CHECK: rx_ready=1; on transfer, compare the received byte with the accumulator. Match: go to DONE with done=1. Mismatch: go to ERROR with error=1.
  - Entering DONE or ERROR: busy=0 and cpu_hold=0, both registered on the same edge as done/error.
- Bytes presented while rx_ready=0 are not consumed; upstream must hold them. rx_valid gaps in any state simply stall that state, with no timeout.
- abort while busy: go to ERROR on the next edge. If asserted during WRITE, prog_we drops at once and the partial write is undefined. abort has no effect when not busy.
- start while busy is ignored. start and abort in the same cycle while busy: abort wins.
- Address wrap: with N == 2**ADDR_WIDTH, prog_addr wraps to 0 after the final write. This is legal; word_count is the terminal test.
- Throughput: 6 byte cycles + 1 setup + WE_CYCLES + 1 hold per word at full rx_valid.

Test Plan:
- Single word: start; stream 01 00, payload 11 22 33 44 55 66, CHK 0x77 -> one prog_we pulse of 2 cycles at addr 0 with data 0x665544332211; then done=1, busy=0, cpu_hold=0, word_count=1.
- Thirteen-word image (12 register/port instructions plus a jump to 0): stream N=0x000D with correct CHK -> 13 writes at addrs 0..12; each prog_data matches the reference word; prog_addr ends at 13; done=1.
- Bad checksum: as the single-word case but CHK 0x00 -> the word is still written; error=1, done=0, cpu_hold drops.
- N=0: stream 00 00 then CHK 00 -> no prog_we; done=1; word_count=0.
- Backpressure: toggle rx_valid every other cycle and present bytes during WRITE -> rx_ready=0 throughout WRITE, no byte lost or duplicated, data identical to the full-rate run.
- Reset mid-load: assert reset after the 3rd payload byte -> all outputs at reset values asynchronously; a following clean load succeeds. Abort mid-payload -> ERROR, error=1, cpu_hold=0.
